// File: rtl/ccd_capture_window.sv
// ccd_capture_window: D5M sensor capture front-end on the pixel clock.
//
// Registers the sensor pins once (r_*), runs a small arm/capture FSM on the
// registered FVAL edges, and emits cropped pixels from a second register stage.
// The delay from the iLVAL pin to oDVAL is therefore two cycles.
//
// Optional feature: define CCD_CAPTURE_DECIM_EN to enable Bayer-preserving 2x
// decimation, selected per frame by iDECIM. Without the macro, iDECIM is ignored.
//
// Ports:
//   iCLK, iRST                 pixel clock, synchronous active-high reset
//   iDATA, iFVAL, iLVAL        sensor pixel bus
//   iSTART / iEND / iSNAP      arm continuous / stop after frame / single frame
//   iDECIM                     2x decimation request (latched at frame start)
//   iX_START..iY_END           inclusive crop window (latched at frame start)
//   oDATA, oDVAL               output pixel (0 when not valid) and valid
//   oX_Cont, oY_Cont           sensor column/row of oDATA
//   oFrame_Cont                accepted-frame count (wraps)
//   oFRAME_DONE                1-cycle pulse at end of an accepted frame
//   oLINE_ERR                  sticky: a line of this frame had the wrong length
//   oBUSY                      FSM not idle
module ccd_capture_window #(
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned COLUMN_WIDTH = 1280,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FRAME_CNT_W  = 32
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [DATA_W-1:0]      iDATA,
  input  logic                   iFVAL,
  input  logic                   iLVAL,
  input  logic                   iSTART,
  input  logic                   iEND,
  input  logic                   iSNAP,
  input  logic                   iDECIM,
  input  logic [CNT_W-1:0]       iX_START,
  input  logic [CNT_W-1:0]       iX_END,
  input  logic [CNT_W-1:0]       iY_START,
  input  logic [CNT_W-1:0]       iY_END,
  output logic [DATA_W-1:0]      oDATA,
  output logic                   oDVAL,
  output logic [CNT_W-1:0]       oX_Cont,
  output logic [CNT_W-1:0]       oY_Cont,
  output logic [FRAME_CNT_W-1:0] oFrame_Cont,
  output logic                   oFRAME_DONE,
  output logic                   oLINE_ERR,
  output logic                   oBUSY
);

  localparam logic [CNT_W-1:0] ColW = CNT_W'(COLUMN_WIDTH);
  localparam logic [CNT_W-1:0] XMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StWait, StActive} state_e;

  // Stage 1: plain pin registers. They keep sampling during reset so that a
  // frame already in progress when reset is released is never seen as a fresh
  // FVAL rising edge (no partial frames after reset).
  logic [DATA_W-1:0] r_data_q;
  logic              r_fval_q, r_lval_q;
  logic              fval_prev_q, lval_prev_q;

  always_ff @(posedge iCLK) begin
    r_data_q    <= iDATA;
    r_fval_q    <= iFVAL;
    r_lval_q    <= iLVAL;
    fval_prev_q <= r_fval_q;
    lval_prev_q <= r_lval_q;
  end

  logic fval_rise, fval_fall, lval_fall;
  assign fval_rise = r_fval_q & ~fval_prev_q;
  assign fval_fall = ~r_fval_q & fval_prev_q;
  assign lval_fall = ~r_lval_q & lval_prev_q;

  // Control state
  state_e                 state_q;
  logic                   cont_q, stop_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   done_q;
  logic [CNT_W-1:0]       xs_q, xe_q, ys_q, ye_q;

  // Mode flags after this cycle's commands; iEND beats iSTART.
  logic cont_nx, stop_nx;
  always_comb begin
    cont_nx = cont_q;
    stop_nx = stop_q;
    if (iEND) begin
      stop_nx = 1'b1;
    end else if (iSTART) begin
      cont_nx = 1'b1;
      stop_nx = 1'b0;
    end
  end

  logic frame_start;
  assign frame_start = (state_q == StWait) & fval_rise & ~iEND;

`ifdef CCD_CAPTURE_DECIM_EN
  logic decim_q;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      decim_q <= 1'b0;
    end else if (frame_start) begin
      decim_q <= iDECIM;
    end
  end
`else
  logic unused_decim;
  assign unused_decim = iDECIM;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= StIdle;
      cont_q      <= 1'b0;
      stop_q      <= 1'b0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      xs_q        <= '0;
      xe_q        <= '0;
      ys_q        <= '0;
      ye_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iEND) begin
            state_q <= StIdle;
          end else if (iSTART) begin
            state_q <= StWait;
            cont_q  <= 1'b1;
            stop_q  <= 1'b0;
          end else if (iSNAP) begin
            state_q <= StWait;
            cont_q  <= 1'b0;
            stop_q  <= 1'b0;
          end
        end
        StWait: begin
          if (iEND) begin
            state_q <= StIdle;
            cont_q  <= 1'b0;
            stop_q  <= 1'b0;
          end else begin
            cont_q <= cont_nx;
            stop_q <= stop_nx;
            if (fval_rise) begin
              state_q     <= StActive;
              frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
              xs_q        <= iX_START;
              xe_q        <= iX_END;
              ys_q        <= iY_START;
              ye_q        <= iY_END;
            end
          end
        end
        StActive: begin
          cont_q <= cont_nx;
          stop_q <= stop_nx;
          if (fval_fall) begin
            done_q <= 1'b1;
            if (cont_nx & ~stop_nx) begin
              state_q <= StWait;
            end else begin
              state_q <= StIdle;
              cont_q  <= 1'b0;
              stop_q  <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Position counters and line-length check
  logic [CNT_W-1:0] x_q, y_q;
  logic             err_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_q   <= '0;
      y_q   <= '0;
      err_q <= 1'b0;
    end else if (frame_start) begin
      x_q   <= '0;
      y_q   <= '0;
      err_q <= 1'b0;
    end else if (state_q == StActive) begin
      if (lval_fall) begin
        x_q <= '0;
        y_q <= y_q + CNT_W'(1);
        if (x_q != ColW) begin
          err_q <= 1'b1;
        end
      end else if (r_lval_q && (x_q != XMax)) begin
        x_q <= x_q + CNT_W'(1);
      end
    end
  end

  // Pixel qualification against the latched window
  logic decim_ok, pix_ok;
`ifdef CCD_CAPTURE_DECIM_EN
  assign decim_ok = ~decim_q | (~x_q[1] & ~y_q[1]);
`else
  assign decim_ok = 1'b1;
`endif

  assign pix_ok = (state_q == StActive) & r_lval_q & (x_q < ColW) &
                  (x_q >= xs_q) & (x_q <= xe_q) & (y_q >= ys_q) & (y_q <= ye_q) & decim_ok;

  // Stage 2: registered pixel outputs
  logic [DATA_W-1:0] data_q;
  logic              dval_q;
  logic [CNT_W-1:0]  ox_q, oy_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      data_q <= '0;
      dval_q <= 1'b0;
      ox_q   <= '0;
      oy_q   <= '0;
    end else begin
      dval_q <= pix_ok;
      data_q <= pix_ok ? r_data_q : '0;
      ox_q   <= pix_ok ? x_q : '0;
      oy_q   <= pix_ok ? y_q : '0;
    end
  end

  assign oDATA       = data_q;
  assign oDVAL       = dval_q;
  assign oX_Cont     = ox_q;
  assign oY_Cont     = oy_q;
  assign oFrame_Cont = frame_cnt_q;
  assign oFRAME_DONE = done_q;
  assign oLINE_ERR   = err_q;
  assign oBUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_ccd_capture_window.sv
// Directed bench for ccd_capture_window: 8-pixel lines, 4-line frames, pixel = {row,col}.
// Expected pixels are queued as lines are driven and popped by a monitor as oDVAL appears.
module tb_ccd_capture_window;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned COLW   = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FCW    = 32;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b1;
  logic [DATA_W-1:0] iDATA = '0;
  logic              iFVAL = 1'b0, iLVAL = 1'b0;
  logic              iSTART = 1'b0, iEND = 1'b0, iSNAP = 1'b0, iDECIM = 1'b0;
  logic [CNT_W-1:0]  iX_START = '0, iX_END = 16'd15, iY_START = '0, iY_END = 16'd15;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic [CNT_W-1:0]  oX_Cont, oY_Cont;
  logic [FCW-1:0]    oFrame_Cont;
  logic              oFRAME_DONE, oLINE_ERR, oBUSY;

  ccd_capture_window #(
    .DATA_W      (DATA_W),
    .COLUMN_WIDTH(COLW),
    .CNT_W       (CNT_W),
    .FRAME_CNT_W (FCW)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iDATA      (iDATA),
    .iFVAL      (iFVAL),
    .iLVAL      (iLVAL),
    .iSTART     (iSTART),
    .iEND       (iEND),
    .iSNAP      (iSNAP),
    .iDECIM     (iDECIM),
    .iX_START   (iX_START),
    .iX_END     (iX_END),
    .iY_START   (iY_START),
    .iY_END     (iY_END),
    .oDATA      (oDATA),
    .oDVAL      (oDVAL),
    .oX_Cont    (oX_Cont),
    .oY_Cont    (oY_Cont),
    .oFrame_Cont(oFrame_Cont),
    .oFRAME_DONE(oFRAME_DONE),
    .oLINE_ERR  (oLINE_ERR),
    .oBUSY      (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;
  int px_cnt = 0;
  int done_cnt = 0;
  bit dec_model = 1'b0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic pulse_start();
    iSTART = 1'b1; cyc(1); iSTART = 1'b0;
  endtask

  task automatic pulse_end();
    iEND = 1'b1; cyc(1); iEND = 1'b0;
  endtask

  task automatic do_reset();
    iRST = 1'b1; cyc(2); iRST = 1'b0; cyc(1);
  endtask

  function automatic bit emit(input int r, input int c);
    logic [1:0] cb, rb;
    cb = c[1:0];
    rb = r[1:0];
    return (c < COLW) && (c >= int'(iX_START)) && (c <= int'(iX_END)) &&
           (r >= int'(iY_START)) && (r <= int'(iY_END)) &&
           (!dec_model || (!cb[1] && !rb[1]));
  endfunction

  // One 4-line frame; short_row gets 7 pixels; end_pulse fires iEND after row 1.
  task automatic frame(input bit cap, input int short_row, input bit end_pulse);
    bit err_exp = 1'b0;
    int len;
    logic [5:0] r6, c6;
    iFVAL = 1'b1;
    cyc(3);
    for (int r = 0; r < 4; r++) begin
      len = (r == short_row) ? COLW - 1 : COLW;
      for (int c = 0; c < len; c++) begin
        r6 = 6'(r);
        c6 = 6'(c);
        iLVAL = 1'b1;
        iDATA = {r6, c6};
        if (cap && emit(r, c)) exp_q.push_back({20'd0, r6, c6, 16'(c), 16'(r)});
        cyc(1);
      end
      iLVAL = 1'b0;
      iDATA = '0;
      cyc(3);
      if (cap) begin
        if (len != COLW) err_exp = 1'b1;
        chk("line_err", oLINE_ERR, err_exp);
      end
      if (end_pulse && r == 1) pulse_end();
    end
    iFVAL = 1'b0;
    cyc(4);
  endtask

  task automatic monitor();
    logic [63:0] e;
    bit done_prev = 1'b0;
    forever begin
      @(negedge iCLK);
      if (oDVAL) begin
        if (exp_q.size() == 0) begin
          chk("px_unexpected_dval", oDVAL, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", {20'd0, oDATA, oX_Cont, oY_Cont}, e);
          px_cnt++;
        end
      end else begin
        chk("idle_data", oDATA, 0);
      end
      if (oFRAME_DONE) begin
        chk("done_width", done_prev, 0);
        done_cnt++;
      end
      done_prev = oFRAME_DONE;
    end
  endtask

  int px0, dn0;

  task automatic mark();
    px0 = px_cnt;
    dn0 = done_cnt;
  endtask

  task automatic finish_test(input string tag, input int px, input int dn, input int fc);
    cyc(2);
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_px"}, px_cnt - px0, px);
    chk({tag, "_done"}, done_cnt - dn0, dn);
    chk({tag, "_fcnt"}, oFrame_Cont, fc);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // 1: reset mid-frame, then re-arm while FVAL is still high
    do_reset();
    mark();
    pulse_start();
    iFVAL = 1'b1;
    cyc(3);
    iLVAL = 1'b1;
    iDATA = 12'h0AB;
    iRST  = 1'b1;
    cyc(2);
    iRST = 1'b0;
    chk("rst_dval", oDVAL, 0);
    chk("rst_data", oDATA, 0);
    chk("rst_x", oX_Cont, 0);
    chk("rst_y", oY_Cont, 0);
    chk("rst_fcnt", oFrame_Cont, 0);
    chk("rst_done", oFRAME_DONE, 0);
    chk("rst_err", oLINE_ERR, 0);
    chk("rst_busy", oBUSY, 0);
    pulse_start();
    chk("rearm_busy", oBUSY, 1);
    cyc(4);
    iLVAL = 1'b0;
    cyc(3);
    iLVAL = 1'b1;
    cyc(8);
    iLVAL = 1'b0;
    cyc(3);
    iFVAL = 1'b0;
    cyc(4);
    finish_test("t1", 0, 0, 0);

    // 2: crop window X 2..5, Y 1..2
    mark();
    iX_START = 16'd2; iX_END = 16'd5; iY_START = 16'd1; iY_END = 16'd2;
    frame(1'b1, -1, 1'b0);
    finish_test("t2", 8, 1, 1);
    pulse_end();
    chk("t2_idle", oBUSY, 0);

    // 3: snapshot captures exactly one frame
    iX_START = 16'd0; iX_END = 16'd15; iY_START = 16'd0; iY_END = 16'd15;
    do_reset();
    mark();
    iSNAP = 1'b1; cyc(1); iSNAP = 1'b0;
    frame(1'b1, -1, 1'b0);
    chk("t3_busy", oBUSY, 0);
    frame(1'b0, -1, 1'b0);
    frame(1'b0, -1, 1'b0);
    finish_test("t3", 32, 1, 1);

    // 4: iEND during frame 2 lets it complete, frame 3 dropped
    do_reset();
    mark();
    pulse_start();
    frame(1'b1, -1, 1'b0);
    frame(1'b1, -1, 1'b1);
    frame(1'b0, -1, 1'b0);
    finish_test("t4", 64, 2, 2);
    chk("t4_busy", oBUSY, 0);

    // 5: short line raises sticky error, cleared at next frame start
    do_reset();
    mark();
    pulse_start();
    frame(1'b1, 2, 1'b0);
    chk("t5_err_held", oLINE_ERR, 1);
    frame(1'b1, -1, 1'b0);
    finish_test("t5", 63, 2, 2);
    pulse_end();

    // 6: decimation request (honoured only when the feature is built in)
    do_reset();
    mark();
`ifdef CCD_CAPTURE_DECIM_EN
    dec_model = 1'b1;
`else
    dec_model = 1'b0;
`endif
    iDECIM = 1'b1;
    pulse_start();
    frame(1'b1, -1, 1'b0);
    finish_test("t6", dec_model ? 8 : 32, 1, 1);
    pulse_end();
    iDECIM = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
